// File: rtl/sram_ctrl.sv
// Pipeline MEM-stage controller for a 16-bit asynchronous SRAM: one 32-bit word is moved as two half-word accesses.
// Define SRAM_READ_BUFFER_EN to add a one-entry read buffer that answers repeated reads without touching the SRAM.
module sram_ctrl #(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC_LO = 2'd1, ACC_HI = 2'd2, DONE = 2'd3} state_t;

   localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

   // Handshake: rd_en/wr_en are held by the pipeline until it sees ready = 1;
   // ready is high when idle with no request, on a buffer hit, or in DONE.
   state_t      state, state_nxt;
   logic [2:0]  wait_cnt;
   logic [16:0] word_q;
   logic [31:0] data_q;
   logic        op_write;
   logic [31:0] rd_q;
   logic [16:0] word_in;
   logic        req, hit, start, last, dq_drive;
   logic [15:0] dq_out;

   assign req     = rd_en | wr_en;
   assign word_in = 17'((address - BASE_ADDR) >> 2);
   assign start   = (state == IDLE) && req && !hit;
   assign last    = (wait_cnt == WAIT_LAST);

`ifdef SRAM_READ_BUFFER_EN
   logic        buf_valid;
   logic [16:0] buf_tag;
   logic [31:0] buf_data;

   assign hit       = (state == IDLE) && rd_en && !wr_en && buf_valid && (buf_tag == word_in);
   assign read_data = hit ? buf_data : rd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
      end else if (state == DONE) begin
         if (!op_write) begin
            buf_valid <= 1'b1;
            buf_tag   <= word_q;
            buf_data  <= rd_q;
         end else if (buf_valid && (buf_tag == word_q)) begin
            buf_data  <= data_q;
         end
      end
   end
`else
   assign hit       = 1'b0;
   assign read_data = rd_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACC_LO;
         ACC_LO:  if (last)  state_nxt = ACC_HI;
         ACC_HI:  if (last)  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == DONE) || ((state == IDLE) && (!req || hit));
      dq_drive  = op_write && ((state == ACC_LO) || (state == ACC_HI));
      SRAM_WE_N = !dq_drive;
      SRAM_OE_N = dq_drive;
      SRAM_ADDR = {word_q, (state == ACC_HI)};
      dq_out    = (state == ACC_HI) ? data_q[31:16] : data_q[15:0];
   end

   assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign dbg_state = state;

   // Request is captured once on leaving IDLE; later input changes are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         word_q   <= '0;
         data_q   <= '0;
         op_write <= 1'b0;
         rd_q     <= '0;
      end else begin
         if (start) begin
            word_q   <= word_in;
            data_q   <= write_data;
            op_write <= wr_en;
         end
         if ((state == ACC_LO) || (state == ACC_HI))
            wait_cnt <= last ? 3'd0 : wait_cnt + 3'd1;
         else
            wait_cnt <= 3'd0;
         if (!op_write && last && (state == ACC_LO)) rd_q[15:0]  <= SRAM_DQ;
         if (!op_write && last && (state == ACC_HI)) rd_q[31:16] <= SRAM_DQ;
`ifdef SRAM_READ_BUFFER_EN
         if (hit) rd_q <= buf_data;
`endif
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed transactions, a behavioural SRAM, and a queue-based scoreboard on completions.
// A second instance with WAIT_CYCLES = 0 covers minimum latency and address wrap.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;
   logic [1:0]  dbg_state;

   logic        rd_en0;
   logic [31:0] address0;
   logic [31:0] read_data0;
   logic        ready0;
   wire  [15:0] sram_dq0;
   logic [17:0] sram_addr0;
   logic        ub0, lb0, we0, ce0, oe0;
   logic [1:0]  dbg_state0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int req_cyc = 0;
   logic [39:0] exp_q[$];
   logic [39:0] e;
   logic [15:0] mem [0:1023];

`ifdef SRAM_READ_BUFFER_EN
   localparam int HIT_LAT = 0;
`else
   localparam int HIT_LAT = 5;
`endif

   sram_ctrl u_dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
      .SRAM_ADDR(sram_addr), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
      .SRAM_WE_N(sram_we_n), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
      .dbg_state(dbg_state)
   );

   sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(1'b0), .address(address0),
      .write_data(32'd0), .read_data(read_data0), .ready(ready0), .SRAM_DQ(sram_dq0),
      .SRAM_ADDR(sram_addr0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
      .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
      .dbg_state(dbg_state0)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural SRAMs
   assign sram_dq  = (!sram_oe_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
   always @(posedge clk) if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq;
   assign sram_dq0 = (!oe0 && we0) ? (sram_addr0[15:0] ^ 16'hA5A5) : 16'hzzzz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: a held request seen with ready high is a completion
   always @(negedge clk) begin
      if (rst && ready && (rd_en || wr_en)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_completion: got read_data %h expected no completion", read_data);
         end else begin
            e = exp_q.pop_front();
            check("read_data", read_data, e[39:8]);
            check("latency", 32'(cyc - req_cyc), {24'd0, e[7:0]});
         end
      end
   end

   // driver: call at posedge+1; returns at posedge+1 after completion
   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd,
                        input int exp_lat, input bit scramble);
      int k;
      exp_q.push_back({exp_rd, 8'(exp_lat)});
      rd_en = rd; wr_en = wr; address = addr; write_data = data;
      req_cyc = cyc;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) break;
         if (scramble && k == 1) begin
            address    = 32'h0000_0F00;
            write_data = 32'h0BAD_0BAD;
         end
      end
      if (k == 40) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got no ready after %0d cycles expected %0d", k, exp_lat);
      end
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] sa;
      int k;
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      rd_en0 = 1'b0; address0 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_read_data", read_data, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd2);
      check("tied_ub_lb_ce", {29'd0, sram_ub_n, sram_lb_n, sram_ce_n}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // write then read back, both WAIT_CYCLES = 1 -> ready in cycle 5
      issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, 5, 1'b0);
      check("mem_hw0", 32'(mem[0]), 32'h0000BEEF);
      check("mem_hw1", 32'(mem[1]), 32'h0000DEAD);
      issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 1'b0);

      // simultaneous rd/wr: the write wins, read_data unchanged
      issue(1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5, 1'b0);
      check("mem_hw2", 32'(mem[2]), 32'h00005678);
      check("mem_hw3", 32'(mem[3]), 32'h00001234);

      // repeated read of the same word (buffer hit when compiled in)
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 5, 1'b0);
      sa = sram_addr;
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, HIT_LAT, 1'b0);
`ifdef SRAM_READ_BUFFER_EN
      check("hit_sram_addr", 32'(sram_addr), 32'(sa));
`endif
      issue(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'h12345678, 5, 1'b0);
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'hCAFEF00D, HIT_LAT, 1'b0);

      // request inputs change mid-transaction: captured values are used
      issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 1'b1);

      // reset in ACC_HI of a write
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h55AA55AA;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dbg_state == 2'd2) break;
      end
      check("reach_acc_hi", 32'(dbg_state), 32'd2);
      rst = 1'b0;
      #1;
      check("midrst_state", 32'(dbg_state), 32'd0);
      check("midrst_we_n", 32'(sram_we_n), 32'd1);
      check("midrst_read_data", read_data, 32'd0);
      check("midrst_dq_released", 32'(sram_dq), 32'(mem[sram_addr[9:0]]));
      wr_en = 1'b0;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(dbg_state), 32'd0);
      @(posedge clk); #1;
      issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 1'b0);

      // WAIT_CYCLES = 0: ready in cycle 3, word address wraps to 0
      rd_en0 = 1'b1; address0 = 32'd525312;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 1) check("w0_acc_lo_addr", 32'(sram_addr0), 32'd0);
         if (ready0) break;
      end
      check("w0_latency", 32'(k), 32'd3);
      check("w0_read_data", read_data0, 32'hA5A4A5A5);
      @(posedge clk); #1;
      rd_en0 = 1'b0;

      repeat (2) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per 16-bit half access, legal range 0..7.
REQ-002 SHALL have parameter BASE_ADDR, default 1024: byte address that maps to SRAM word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rd_en, input, 1: read request from the MEM stage, held until ready.
REQ-006 SHALL have port wr_en, input, 1: write request from the MEM stage, held until ready.
REQ-007 SHALL have port address, input, 32: byte address of the request.
REQ-008 SHALL have port write_data, input, 32: write word.
REQ-009 SHALL have port read_data, output, 32: last completed read word.
REQ-010 SHALL have port ready, output, 1: 0 stalls the pipeline; 1 means idle or transaction complete.
REQ-011 SHALL have port SRAM_DQ, inout, 16: SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR, output, 18: SRAM half-word address.
REQ-013 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N and SRAM_OE_N, each output, 1: active-low SRAM controls.

Function
REQ-014 SHALL implement FSM states IDLE, ACC_LO, ACC_HI and DONE.
REQ-015 SHALL transition IDLE->ACC_LO on rd_en or wr_en, ACC_LO->ACC_HI and ACC_HI->DONE after WAIT_CYCLES+1 cycles each via a wait counter, and DONE->IDLE unconditionally.
REQ-016 SHALL drive ready = 1 in DONE or in IDLE with no request, else 0, so that ready is combinationally low in IDLE as soon as a request is present.
REQ-017 SHALL, for a request first sampled in IDLE at cycle 0, assert ready in cycle 2*WAIT_CYCLES+3 (cycle 5 at default).
REQ-018 SHALL compute word address = (address - BASE_ADDR) >> 2, truncated to 17 bits, wrapping modulo 2^17.
REQ-019 SHALL drive SRAM_ADDR = {word,0} in ACC_LO and {word,1} in ACC_HI.
REQ-020 SHALL capture address, write_data and operation type on IDLE exit; changes to or deassertion of request inputs mid-transaction SHALL be ignored.
REQ-021 SHALL give a write priority when rd_en and wr_en are both asserted.
REQ-022 SHALL, on a write, drive SRAM_DQ = write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI, with SRAM_WE_N = 0 and SRAM_OE_N = 1 in those states.
REQ-023 SHALL otherwise hold SRAM_DQ at high-Z, SRAM_WE_N = 1 and SRAM_OE_N = 0.
REQ-024 SHALL, on a read, latch SRAM_DQ into read_data[15:0] on the last ACC_LO cycle and into read_data[31:16] on the last ACC_HI cycle.
REQ-025 SHALL hold read_data until the next read completes; writes SHALL not alter read_data.
REQ-026 SHALL tie SRAM_UB_N, SRAM_LB_N and SRAM_CE_N to 0.
REQ-027 SHALL accept back-to-back requests, entering ACC_LO again from IDLE on the cycle after DONE if a request is present.

Reset
REQ-028 SHALL, while rst = 0, force at any state (including mid-transaction): state IDLE, wait counter 0, read_data 0, SRAM_WE_N 1, SRAM_DQ high-Z, ready = 1 absent a request.
REQ-029 SHALL, on rst deassertion, start no transaction until a request is sampled in IDLE.

Configuration
REQ-030 SHALL compile in, with macro SRAM_READ_BUFFER_EN defined, a one-entry read buffer (valid bit, 17-bit tag, 32-bit data); absent the macro, every read SHALL run the full FSM sequence and no buffer logic SHALL exist.
REQ-031 SHALL, with SRAM_READ_BUFFER_EN, make a read whose tag matches the valid entry, sampled in IDLE, a hit: ready stays 1, read_data = buffer data in the same cycle, and there is no SRAM access.
REQ-032 SHALL, with SRAM_READ_BUFFER_EN, load the buffer entry on each completed read miss, update it with write_data on a completed write to the matching tag, and clear the valid bit on reset.

Verification
REQ-033 SHALL verify reset: rst = 0 during ACC_HI of a write -> next cycle IDLE, SRAM_WE_N = 1, SRAM_DQ high-Z, read_data 0.
REQ-034 SHALL verify write: wr_en, address 1024, 0xDEADBEEF -> SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD, ready high in cycle 5.
REQ-035 SHALL verify read: rd_en, address 1024 after REQ-034 -> read_data 0xDEADBEEF, ready high in cycle 5.
REQ-036 SHALL verify priority: rd_en = wr_en = 1, address 1028, 0x12345678 -> write performed; read_data unchanged.
REQ-037 SHALL verify timing: WAIT_CYCLES = 0, read -> ready in cycle 3; address 1024 + 4*2^17 -> SRAM_ADDR 0 (wrap).
REQ-038 SHALL verify buffer (SRAM_READ_BUFFER_EN): repeated read of 1028 -> ready stays 1, no SRAM_ADDR change; write 0xCAFEF00D to 1028, then read -> 0xCAFEF00D.
